// File: rtl/seg_pkg.sv
// seg_pkg: shared types and default parameters for the multiplexed display scanner
package seg_pkg;
  typedef enum logic {EMPTY, PENDING} buf_state_t;
  typedef logic [3:0] nibble_t;
  localparam int DEF_NDIGITS = 4;
  localparam int DEF_DIV = 50000;
endpackage

// File: rtl/seg_prescaler.sv
// seg_prescaler: free-running 0..DIV-1 counter producing a one-cycle tick on the last count
module seg_prescaler
  import seg_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/seg_scan.sv
// seg_scan: double-buffered hex digit scanner with frame-aligned commit and leading-zero blanking
module seg_scan
  import seg_pkg::*;
#(
  parameter int NDIGITS = DEF_NDIGITS,
  parameter int DIV = DEF_DIV
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [4*NDIGITS-1:0]   load_data,
  input  logic                   blank_lz,
  output logic [3:0]             digit_data,
  output logic [NDIGITS-1:0]     digit_sel,
  output logic                   digit_blank
);
  localparam int IW = $clog2(NDIGITS);
  localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);
  logic tick, frame_end, blz_q, hi_zero;
  logic [IW-1:0] idx;
  nibble_t [NDIGITS-1:0] disp, pend;
  buf_state_t st;
  seg_prescaler #(.DIV(DIV)) u_pre (.clk(clk), .rst_n(rst_n), .tick(tick));
  assign frame_end = tick & (idx == LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx <= '0;
    else if (tick) idx <= (idx == LAST) ? '0 : idx + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) blz_q <= 1'b0;
    else blz_q <= blank_lz;
  // a handshake landing on frame_end only fills pend; it waits a whole frame to commit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= EMPTY;
      pend <= '0;
      disp <= '0;
    end else if (st == EMPTY) begin
      if (load_valid) begin
        pend <= load_data;
        st <= PENDING;
      end
    end else if (frame_end) begin
      disp <= pend;
      st <= EMPTY;
    end
  always_comb begin
    hi_zero = 1'b1;
    for (int k = 0; k < NDIGITS; k++) hi_zero &= (k < int'(idx)) || (disp[k] == '0);
  end
  assign load_ready = st == EMPTY;
  assign digit_data = disp[idx];
  assign digit_sel = NDIGITS'(1) << idx;
  assign digit_blank = blz_q & (idx != '0) & hi_zero;
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized scoreboard bench for seg_scan against a cycle-count reference model
module tb_seg_scan;
  localparam int N = 4, D = 4, F = N * D;
  logic clk = 0, rst_n = 0, load_valid = 0, blank_lz = 0;
  logic [15:0] load_data = '0;
  logic load_ready, digit_blank;
  logic [3:0] digit_data, digit_sel;
  seg_scan #(.NDIGITS(N), .DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .blank_lz(blank_lz), .digit_data(digit_data),
    .digit_sel(digit_sel), .digit_blank(digit_blank)
  );
  always #5 clk = ~clk;
  typedef struct {logic [3:0] sel; logic [3:0] data; logic blank; logic ready;} exp_t;
  exp_t q[$];
  exp_t me, ce;
  int tests = 0, fails = 0, cyc = 0, mi;
  logic [15:0] m_disp = '0, m_pend = '0;
  bit m_has = 0, m_blz = 0;
  // model: cyc counts edges since reset; frames are F edges, each digit shown for D edges
  always @(posedge clk) begin
    if (!rst_n) begin
      m_disp = '0; m_pend = '0; m_has = 0; m_blz = 0; cyc = 0;
    end else begin
      if (m_has && cyc % F == F - 1) begin
        m_disp = m_pend; m_has = 0;
      end else if (!m_has && load_valid) begin
        m_pend = load_data; m_has = 1;
      end
      m_blz = blank_lz;
      cyc++;
    end
    mi = (cyc / D) % N;
    me.sel = 4'(1 << mi);
    me.data = 4'(m_disp >> (4 * mi));
    me.blank = m_blz && mi != 0 && (m_disp >> (4 * mi)) == 0;
    me.ready = !m_has;
    q.push_back(me);
  end
  always @(negedge clk) if (q.size() > 0) begin
    ce = q.pop_front();
    tests++;
    if ({digit_sel, digit_data, digit_blank, load_ready} !== {ce.sel, ce.data, ce.blank, ce.ready}) begin
      fails++;
      $display("FAIL scan t=%0t got sel=%b data=%h blank=%b ready=%b want sel=%b data=%h blank=%b ready=%b",
               $time, digit_sel, digit_data, digit_blank, load_ready, ce.sel, ce.data, ce.blank, ce.ready);
    end
  end
  task automatic chk(string n, logic [9:0] act, logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %b want %b", n, act, exp);
    end
  endtask
  task automatic send(logic [15:0] d);
    bit acc = 0;
    load_valid = 1; load_data = d;
    for (int n = 0; n < 3 * F && !acc; n++) begin
      acc = load_ready;
      @(negedge clk);
    end
    load_valid = 0; load_data = 16'($urandom);
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL send_timeout got no handshake want accept of %h", d);
    end
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_phase(int p);
    for (int n = 0; n < F && cyc % F != p; n++) @(negedge clk);
  endtask
  task automatic do_reset();
    #1 rst_n = 0;
    #1 chk("reset_async", {load_ready, digit_sel, digit_data, digit_blank}, {1'b1, 4'b0001, 4'h0, 1'b0});
    idle(2);
    #1 rst_n = 1;
  endtask
  initial begin
    idle(2);
    rst_n = 1;
    idle(2);
    send(16'h4321); idle(2 * F);
    send(16'hA5A5); send(16'hBEEF); idle(2 * F);
    wait_phase(F - 1); send(16'h00F0); idle(2 * F);
    blank_lz = 1;
    send(16'h0050); idle(2 * F);
    send(16'h0000); idle(2 * F);
    send(16'h7008); idle(7);
    do_reset(); idle(F + 3);
    send(16'h1234); idle(3);
    do_reset(); idle(2 * F);
    repeat (40) begin
      blank_lz = 1'($urandom);
      idle($urandom_range(0, 20));
      send(16'($urandom));
      if ($urandom_range(0, 15) == 0) do_reset();
    end
    idle(2 * F);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed hex-display scanner that sits directly upstream of the `sevenseg` decoder. It holds NDIGITS 4-bit digits and time-multiplexes one digit at a time onto the decoder's 4-bit `data` input, driving a one-hot digit select. New display values are accepted through a valid/ready handshake. They are double-buffered and committed only at a frame boundary, so the display never tears. Optional leading-zero blanking is supported.

## Interface
- NDIGITS, 4, number of multiplexed digits (2..8)
- DIV, 50000, clock cycles each digit is held (>=2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_valid  input  1  load_data presented
- load_ready  output  1  pending buffer free; transfer when load_valid & load_ready at rising edge
- load_data  input  4*NDIGITS  digit k in bits [4k+3:4k]; digit 0 is least significant, rightmost
- blank_lz  input  1  enable leading-zero blanking; quasi-static, registered internally
- digit_data  output  4  nibble to sevenseg `data`
- digit_sel  output  NDIGITS  one-hot active-high select; bit k means digit k is shown
- digit_blank  output  1  high means the current digit is blanked; downstream forces segments off

## Operation
- Prescaler `cnt` counts 0..DIV-1 and wraps. `tick` = (cnt == DIV-1).
- Scan index `idx` increments on `tick` and wraps from NDIGITS-1 to 0.
- `frame_end` = tick & (idx == NDIGITS-1).
- Registers:
  - `disp`: displayed digits.
  - `pend`: pending digits.
  - FSM `st` in {EMPTY, PENDING}.
- load_ready = (st == EMPTY).
- FSM transitions:
  - EMPTY, on handshake: pend <= load_data, go to PENDING.
  - PENDING, on frame_end: disp <= pend, go to EMPTY.
  - All other cases hold state.
- Same cycle in EMPTY with handshake and frame_end: data goes to pend only. It commits at the next frame_end; there is no bypass into disp.
- In PENDING, load_ready = 0, so load_valid is ignored. The upstream source must hold load_data until it is accepted.
- digit_data = disp[idx]. digit_sel = 1 << idx.
- digit_blank = blz_q & (idx != 0) & (disp digits idx..NDIGITS-1 all zero). Digit 0 is never blanked.
- blz_q is blank_lz registered on every clk.
- No combinational path from any input to any output. Outputs decode registered state only.

## Timing
- Reset values (async, immediate):
  - cnt=0, idx=0, st=EMPTY, disp=0, pend=0, blz_q=0.
  - So load_ready=1, digit_sel=1 (digit 0 selected), digit_data=0, digit_blank=0.
- Each digit is selected for exactly DIV cycles. A full frame is NDIGITS*DIV cycles.
- Load-to-display latency: a value accepted at edge E appears on digit 0 at the first frame_end edge after E. Worst case is NDIGITS*DIV cycles.
- load_ready falls on the edge after a handshake. It rises on the edge that performs the commit.
- An accepted load always commits exactly once. Back-to-back loads are limited to one per frame.
- Reset mid-frame discards pend and restarts scanning at digit 0, cnt=0.
- blank_lz changes take effect one cycle later.

## Structure
- Package `seg_pkg`:
  - `typedef enum logic {EMPTY, PENDING} buf_state_t;`
  - `typedef logic [3:0] nibble_t;`
  - default constants for NDIGITS and DIV.
- Sub-module `seg_prescaler`:
  - parameter DIV; ports clk, rst_n, tick.
  - Reused by other display blocks.
- seg_scan instantiates seg_prescaler and holds idx, disp, pend, FSM and output decode.
- Top-level pairing: seg_scan.digit_data drives sevenseg data. digit_blank gates its segments.

## Test plan
All tests use NDIGITS=4, DIV=4 (frame = 16 cycles).
- Reset check:
  - Stimulus: assert rst_n=0 mid-count.
  - Required: outputs immediately take reset values (digit_sel=4'b0001, digit_data=0, load_ready=1). After release, digit_sel steps 0001, 0010, 0100, 1000, 0001, each held 4 cycles.
- Load and commit:
  - Stimulus: load 16'h4321 in cycle 2.
  - Required: load_ready=0 from cycle 3. At the frame_end edge (cycle 15), disp=4321 and load_ready=1. From then on, digit_data reads 1,2,3,4 across digits 0..3.
- Backpressure:
  - Stimulus: hold load_valid with 16'hBEEF immediately after loading 16'hA5A5.
  - Required: BEEF is not accepted until the commit edge. The display shows A5A5 for one full frame, then BEEF.
- Simultaneous handshake and frame_end:
  - Stimulus: handshake 16'h00F0 exactly on a frame_end edge.
  - Required: disp is unchanged in that frame. 00F0 appears after the next frame_end.
- Leading-zero blanking:
  - Stimulus: disp=16'h0050 with blank_lz=1.
  - Required: digit_blank=1 on digits 3 and 2, 0 on digits 1 and 0. With disp=0, only digit 0 is unblanked.
- Reset mid-pending:
  - Stimulus: assert rst_n=0 while st=PENDING.
  - Required: after release, disp=0, load_ready=1, and the old pend value never appears.
